bist_pattern_gen: RTL and testbench
===================================

BIST_PATTERN_GEN -- requirements
Module: bist_pattern_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8: LFSR and pattern width, legal range 3..32.
REQ-002 SHALL have parameter TAPS, WIDTH bits, default 8'hB8: feedback tap mask.
REQ-003 SHALL have parameter SEED, WIDTH bits, default 8'h01: fallback seed; must be nonzero.
REQ-004 SHALL have parameter GALOIS, default 0: 0 selects Fibonacci update, 1 selects Galois update.
REQ-005 SHALL have parameter CW, default 16: width of the pattern counter.
REQ-006 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have port start, input, 1 bit: single-cycle request to begin a run.
REQ-009 SHALL have port abort, input, 1 bit: terminates a run and returns to IDLE.
REQ-010 SHALL have port seed_sel, input, 1 bit: 1 uses seed_in, 0 uses SEED; sampled at start.
REQ-011 SHALL have port seed_in, input, WIDTH bits: run-time seed.
REQ-012 SHALL have port cnt_max, input, CW bits: number of patterns per run; sampled at start.
REQ-013 SHALL have port pat_ready, input, 1 bit: consumer accepts pat.
REQ-014 SHALL have port pat, output, WIDTH bits: current pattern.
REQ-015 SHALL have port pat_valid, output, 1 bit: pat is valid.
REQ-016 SHALL have port pat_idx, output, CW bits: index of the current pattern, starting at 0.
REQ-017 SHALL have port busy, output, 1 bit: high in RUN.
REQ-018 SHALL have port done, output, 1 bit: high in DONE.
REQ-019 SHALL have port lockup, output, 1 bit: sticky flag for zero-state substitution.

Function
REQ-020 SHALL implement FSM states IDLE, RUN and DONE.
REQ-021 SHALL move to RUN on start when in IDLE or DONE; start is ignored while in RUN.
REQ-022 SHALL, on the start cycle, load q with the selected seed, latch cnt_max, clear pat_idx and clear lockup.
REQ-023 SHALL substitute SEED for a selected seed of zero and set lockup.
REQ-024 SHALL, when started with latched cnt_max==0, go directly to DONE with pat_valid never asserted.
REQ-025 SHALL hold pat_valid=1 and pat=q throughout RUN, first asserting one cycle after start.
REQ-026 SHALL, in RUN, hold pat/q and pat_idx stable while pat_ready=0.
REQ-027 SHALL treat a cycle with pat_valid && pat_ready as acceptance.
REQ-028 SHALL, on acceptance, advance q one LFSR step and increment pat_idx.
REQ-029 SHALL, on the acceptance at pat_idx==cnt_max-1, enter DONE instead, with pat_valid low the next cycle.
REQ-030 SHALL, in Fibonacci mode, compute q_next = {q[WIDTH-2:0], ^(q & TAPS)}.
REQ-031 SHALL, in Galois mode, compute q_next = {q[WIDTH-2:0],1'b0} ^ (TAPS masked by q[WIDTH-1]).
REQ-032 SHALL, if q_next would be all-zero, load SEED instead and set lockup.
REQ-033 SHALL hold lockup set until the next start or reset.
REQ-034 SHALL wrap pat_idx modulo 2^CW with no other effect.
REQ-035 SHALL, in DONE, hold done=1 and keep pat and pat_idx at their last values until start or abort.
REQ-036 SHALL, on abort in RUN or DONE, enter IDLE next cycle with pat_valid=0, done=0, busy=0 and q unchanged.
REQ-037 SHALL give abort priority when start and abort are asserted in the same cycle, ending in IDLE.
REQ-038 SHALL drive busy=1 exactly in RUN and done=1 exactly in DONE; both are registered.

Reset
REQ-039 SHALL, on rst=1, immediately force state IDLE, q=SEED, pat=SEED, pat_idx=0, pat_valid=0, busy=0, done=0 and lockup=0.
REQ-040 SHALL, on rst asserted mid-run, discard the run; no pattern is accepted after the reset edge.

Verification
REQ-041 SHALL cover the following scenario: WIDTH=8, TAPS=B8, Fibonacci, seed_sel=0, cnt_max=5, pat_ready=1 -> pats 01,02,04,08,11, then done=1 with pat_idx=4.
REQ-042 SHALL cover the following scenario: same run with pat_ready toggling 1/0 -> identical sequence, each pat held while not ready, no skipped or duplicated values.
REQ-043 SHALL cover the following scenario: seed_sel=1, seed_in=00 -> first pat=01, lockup=1; the next start with seed_in=5A -> lockup=0, first pat=5A.
REQ-044 SHALL cover the following scenario: cnt_max=0 start -> DONE the next cycle with pat_valid never high; cnt_max=255 full run -> 255 distinct nonzero patterns.
REQ-045 SHALL cover the following scenario: abort and start together at pattern 3 -> IDLE, pat_valid=0, done=0; rst at pattern 2 -> all outputs at reset values in the same cycle.
REQ-046 SHALL cover the following scenario: GALOIS=1, WIDTH=16, TAPS=002D, seed 0001, 65535 accepts -> q returns to 0001 and lockup stays 0.

Source files
------------

// File: rtl/bist_pattern_gen.sv
// rtl/bist_pattern_gen.sv - LFSR BIST pattern generator with valid/ready output handshake
// Fibonacci or Galois LFSR; a zero seed or zero next state is replaced by SEED and flagged.
module bist_pattern_gen #(
  parameter int              WIDTH  = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01,
  parameter int              GALOIS = 0,
  parameter int              CW     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             seed_sel,
  input  logic [WIDTH-1:0] seed_in,
  input  logic [CW-1:0]    cnt_max,
  input  logic             pat_ready,
  output logic [WIDTH-1:0] pat,
  output logic             pat_valid,
  output logic [CW-1:0]    pat_idx,
  output logic             busy,
  output logic             done,
  output logic             lockup
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] q;
  logic [CW-1:0]    cnt_lat;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] seed_pick;
  logic             step_zero;
  logic             seed_zero;
  logic             last_accept;

  always_comb begin
    step = '0;
    if (GALOIS != 0) begin
      step = {q[WIDTH-2:0], 1'b0} ^ (q[WIDTH-1] ? TAPS : '0);
    end else begin
      step = {q[WIDTH-2:0], ^(q & TAPS)};
    end
  end

  assign seed_pick   = seed_sel ? seed_in : SEED;
  assign seed_zero   = (seed_pick == '0);
  assign step_zero   = (step == '0);
  assign last_accept = (pat_idx == cnt_lat - CW'(1));
  assign pat         = q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      q         <= SEED;
      cnt_lat   <= '0;
      pat_idx   <= '0;
      pat_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      lockup    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // abort wins over a simultaneous start
          if (abort) begin
            state     <= IDLE;
            pat_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
          end else if (start) begin
            q       <= seed_zero ? SEED : seed_pick;
            lockup  <= seed_zero;
            cnt_lat <= cnt_max;
            pat_idx <= '0;
            if (cnt_max == '0) begin
              state     <= DONE;
              pat_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              state     <= RUN;
              pat_valid <= 1'b1;
              busy      <= 1'b1;
              done      <= 1'b0;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state     <= IDLE;
            pat_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
          end else if (pat_ready) begin
            if (last_accept) begin
              state     <= DONE;
              pat_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              pat_idx <= pat_idx + CW'(1);
              q       <= step_zero ? SEED : step;
              if (step_zero) lockup <= 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          pat_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bist_pattern_gen.sv
// tb/tb_bist_pattern_gen.sv - scoreboard bench for bist_pattern_gen (8-bit Fibonacci and 16-bit Galois)
module tb_bist_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, abort, seed_sel, pat_ready;
  logic [7:0]  seed_in;
  logic [15:0] cnt_max;
  logic [7:0]  pat;
  logic        pat_valid, busy, done, lockup;
  logic [15:0] pat_idx;

  logic        g_start, g_abort, g_ready;
  logic [16:0] g_cnt_max;
  logic [15:0] g_pat;
  logic        g_valid, g_busy, g_done, g_lockup;
  logic [16:0] g_idx;

  bist_pattern_gen dut8 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .seed_sel(seed_sel),
    .seed_in(seed_in), .cnt_max(cnt_max), .pat_ready(pat_ready), .pat(pat),
    .pat_valid(pat_valid), .pat_idx(pat_idx), .busy(busy), .done(done), .lockup(lockup)
  );

  bist_pattern_gen #(
    .WIDTH(16), .TAPS(16'h002D), .SEED(16'h0001), .GALOIS(1), .CW(17)
  ) dut16 (
    .clk(clk), .rst(rst), .start(g_start), .abort(g_abort), .seed_sel(1'b0),
    .seed_in(16'h0000), .cnt_max(g_cnt_max), .pat_ready(g_ready), .pat(g_pat),
    .pat_valid(g_valid), .pat_idx(g_idx), .busy(g_busy), .done(g_done), .lockup(g_lockup)
  );

  typedef struct {
    logic [31:0] p;
    int          idx;
  } exp_t;

  exp_t        q8[$];
  exp_t        q16[$];
  logic [31:0] runpat[$];
  int          checks = 0;
  int          passed = 0;
  bit          track = 0;
  bit          seen[256];
  int          dups = 0;
  int          nseen = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference LFSR step written as shift + parity arithmetic on plain integers
  function automatic logic [31:0] lfsr_next(logic [31:0] s, logic [31:0] taps, int w, bit galois);
    logic [31:0] mask;
    logic [31:0] shifted;
    int          ones;
    mask    = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    shifted = (s << 1) & mask;
    if (galois) return s[w-1] ? (shifted ^ taps) : shifted;
    ones = 0;
    for (int i = 0; i < w; i++) if (s[i] && taps[i]) ones++;
    return shifted | 32'(ones % 2);
  endfunction

  task automatic expect_run(logic [31:0] seed, logic [31:0] fallback, logic [31:0] taps, int w,
                            bit galois, int n, bit wide, output bit lk);
    logic [31:0] s;
    logic [31:0] nx;
    exp_t        e;
    lk = 0;
    s  = seed;
    if (s == 0) begin s = fallback; lk = 1; end
    runpat.delete();
    for (int i = 0; i < n; i++) begin
      e.p = s; e.idx = i;
      if (wide) q16.push_back(e); else q8.push_back(e);
      runpat.push_back(s);
      if (i < n - 1) begin
        nx = lfsr_next(s, taps, w, galois);
        if (nx == 0) begin nx = fallback; lk = 1; end
        s = nx;
      end
    end
  endtask

  // 8-bit scoreboard monitor: pops on every acceptance, and checks stall stability
  initial begin
    exp_t        e;
    bit          holding;
    logic [23:0] hold_val;
    holding = 0;
    hold_val = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        holding = 0;
      end else begin
        if (holding && pat_valid) chk("hold_stable", {pat_idx, pat}, hold_val);
        holding  = pat_valid && !pat_ready;
        hold_val = {pat_idx, pat};
        if (pat_valid && pat_ready) begin
          if (q8.size() == 0) begin
            checks++;
            $display("FAIL sb8_unexpected: got pat %0h idx %0d expected no acceptance", pat, pat_idx);
          end else begin
            e = q8.pop_front();
            chk("sb8_pattern", {pat_idx, pat}, {16'(e.idx), e.p[7:0]});
          end
          if (track) begin
            if (seen[pat] || pat == 8'h00) dups++;
            else nseen++;
            seen[pat] = 1;
          end
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && g_valid && g_ready) begin
        if (q16.size() == 0) begin
          checks++;
          $display("FAIL sb16_unexpected: got pat %0h expected no acceptance", g_pat);
        end else begin
          e = q16.pop_front();
          chk("sb16_pattern", {g_idx, g_pat}, {17'(e.idx), e.p[15:0]});
        end
      end
    end
  end

  task automatic start8(bit sel, logic [7:0] sin, int n, output bit lk);
    expect_run(sel ? {24'h0, sin} : 32'h01, 32'h01, 32'hB8, 8, 0, n, 0, lk);
    seed_sel = sel;
    seed_in  = sin;
    cnt_max  = 16'(n);
    start    = 1;
    tick;
    start    = 0;
  endtask

  task automatic run8(bit sel, logic [7:0] sin, int n, int mode);
    bit          lk;
    logic [31:0] first;
    logic [31:0] last;
    start8(sel, sin, n, lk);
    if (n > 0) begin
      first = runpat[0];
      last  = runpat[n-1];
      chk("first_valid", pat_valid, 1);
      chk("first_busy", busy, 1);
      chk("first_pat", pat, first[7:0]);
    end else begin
      chk("zero_done", done, 1);
      chk("zero_valid", pat_valid, 0);
    end
    for (int c = 0; c < 3000 && !done; c++) begin
      case (mode)
        0: pat_ready = 1;
        1: pat_ready = c[0];
        default: begin
          pat_ready = 1'($urandom_range(0, 1));
          start     = ($urandom_range(0, 3) == 0);
          seed_in   = 8'($urandom);
          cnt_max   = 16'($urandom);
        end
      endcase
      tick;
      if (n == 0) chk("zero_never_valid", pat_valid, 0);
    end
    start     = 0;
    pat_ready = 0;
    chk("run_done", done, 1);
    chk("run_busy_low", busy, 0);
    chk("run_valid_low", pat_valid, 0);
    chk("run_idx", pat_idx, (n > 0) ? n - 1 : 0);
    if (n > 0) chk("run_last_pat", pat, last[7:0]);
    chk("run_lockup", lockup, lk);
    chk("run_drained", q8.size(), 0);
    tick;
    chk("done_hold", {done, pat_valid}, 2'b10);
  endtask

  initial begin
    bit          lk;
    logic [31:0] keep;
    rst = 1; start = 0; abort = 0; seed_sel = 0; pat_ready = 0; seed_in = 0; cnt_max = 0;
    g_start = 0; g_abort = 0; g_ready = 0; g_cnt_max = 0;
    #1;
    chk("rst_pat", pat, 8'h01);
    chk("rst_flags", {pat_valid, busy, done, lockup}, 4'b0000);
    chk("rst_idx", pat_idx, 0);
    chk("rst_g_pat", g_pat, 16'h0001);
    tick;
    rst = 0;
    tick;

    run8(0, 8'h00, 5, 0);
    run8(0, 8'h00, 5, 1);
    run8(1, 8'h00, 3, 2);
    run8(1, 8'h5A, 3, 0);
    run8(0, 8'h00, 0, 0);
    for (int k = 0; k < 4; k++) run8(1, 8'($urandom_range(0, 255)), $urandom_range(1, 40), 2);

    for (int i = 0; i < 256; i++) seen[i] = 0;
    track = 1;
    run8(0, 8'h00, 255, 0);
    track = 0;
    chk("distinct255_dups", dups, 0);
    chk("distinct255_count", nseen, 255);

    // abort together with start while pattern 3 is presented
    start8(0, 8'h00, 10, lk);
    pat_ready = 1;
    for (int c = 0; c < 50 && pat_idx != 3; c++) tick;
    chk("abort_reach_idx3", pat_idx, 3);
    keep = runpat[3];
    pat_ready = 0; abort = 1; start = 1;
    tick;
    abort = 0; start = 0;
    chk("abort_flags", {pat_valid, busy, done}, 3'b000);
    chk("abort_q_kept", pat, keep[7:0]);
    q8.delete();
    tick;
    chk("abort_stays_idle", {pat_valid, busy, done}, 3'b000);

    // asynchronous reset in the middle of a run
    start8(1, 8'h00, 10, lk);
    pat_ready = 1;
    for (int c = 0; c < 50 && pat_idx != 2; c++) tick;
    chk("rst_reach_idx2", pat_idx, 2);
    rst = 1;
    #1;
    chk("midrst_pat", pat, 8'h01);
    chk("midrst_flags", {pat_valid, busy, done, lockup}, 4'b0000);
    chk("midrst_idx", pat_idx, 0);
    tick;
    q8.delete();
    rst = 0;
    pat_ready = 0;
    tick;
    chk("after_rst_idle", {pat_valid, busy, done}, 3'b000);

    // 16-bit Galois full period: 65535 advancing accepts return to the seed
    expect_run(32'h0001, 32'h0001, 32'h002D, 16, 1, 65536, 1, lk);
    keep = runpat[65535];
    g_cnt_max = 17'd65536;
    g_start = 1;
    tick;
    g_start = 0;
    g_ready = 1;
    for (int c = 0; c < 70000 && !g_done; c++) tick;
    g_ready = 0;
    chk("g_done", g_done, 1);
    chk("g_final_pat", g_pat, keep[15:0]);
    chk("g_lockup", g_lockup, lk);
    chk("g_drained", q16.size(), 0);
    tick;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
